// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the data-cache controller state encoding and defaults.
// The block address helper is shared by the controller and anything decoding fills.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        FETCH0,
        FETCH1,
        FLUSH,
        FWB0,
        FWB1,
        CNT,
        DONE
    } dctrl_state_t;

    localparam word_t HITCNT_ADDR_DEF = 32'h0000_3100;

    // Word address inside a two-word block: bit 2 selects the word.
    function automatic word_t block_word_addr(input word_t base, input logic word);
        return {base[31:3], word, 2'b00};
    endfunction

endpackage

// File: rtl/hit_counter.sv
// Wrap-around hit counter for the data cache.
// The cycle right after a fill is ignored so a refilled request counts only as a miss.
module hit_counter
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  i_hit_event,
    input  logic  i_fill_done,
    output word_t o_count
);

    word_t r_count;
    logic  r_suppress;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count    <= '0;
            r_suppress <= 1'b0;
        end else begin
            // fill_done is a single-cycle pulse, so the flag covers exactly one cycle.
            r_suppress <= i_fill_done;
            if (i_hit_event && !r_suppress) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss, writeback and flush sequencer between the data store and the memory arbiter.
// Memory request outputs are decoded from state; completion pulses also qualify on dwait.
module dcache_ctrl
    import cpu_types_pkg::*;
#(
    parameter int    NFRAMES     = 16,
    parameter word_t HITCNT_ADDR = HITCNT_ADDR_DEF,
    localparam int   IDXW        = $clog2(NFRAMES)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            dmemREN,
    input  logic            dmemWEN,
    input  logic            halt,
    input  logic            hit,
    input  logic            victim_dirty,
    input  word_t           victim_addr,
    input  word_t           victim_data,
    input  logic            flush_dirty,
    input  word_t           flush_addr,
    input  word_t           flush_data,
    input  word_t           dmemaddr,
    output logic            word_sel,
    output logic            fill_wen,
    output logic            fill_done,
    output logic            clean,
    output logic [IDXW-1:0] flush_idx,
    output logic            dREN,
    output logic            dWEN,
    output word_t           daddr,
    output word_t           dstore,
    input  logic            dwait,
    input  word_t           dload,
    output logic            flushed,
    output dctrl_state_t    dbg_state
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFRAMES - 1);

    dctrl_state_t    r_state;
    logic [IDXW-1:0] r_flush_idx;

    logic  w_req;
    logic  w_done;
    logic  w_hit_event;
    word_t w_hit_count;
    logic  w_dren;
    logic  w_dwen;
    word_t w_daddr;
    word_t w_dstore;
    logic  w_word_sel;
    logic  w_unused;

    assign w_req       = dmemREN | dmemWEN;
    assign w_done      = !dwait;
    assign w_hit_event = (r_state == IDLE) && w_req && hit;
    // Fill data arrives through the access logic, not here; low address bits are word-internal.
    assign w_unused    = &{1'b0, dload, dmemaddr[1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_flush_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A pending miss takes priority over halt.
                    if (w_req && !hit) begin
                        r_state <= victim_dirty ? WB0 : FETCH0;
                    end else if (halt) begin
                        r_state     <= FLUSH;
                        r_flush_idx <= '0;
                    end
                end
                WB0: if (w_done) r_state <= WB1;
                WB1: if (w_done) r_state <= FETCH0;
                FETCH0: if (w_done) r_state <= FETCH1;
                FETCH1: if (w_done) r_state <= IDLE;
                FLUSH: begin
                    if (flush_dirty) begin
                        r_state <= FWB0;
                    end else if (r_flush_idx == LAST_IDX) begin
                        r_state <= CNT;
                    end else begin
                        r_flush_idx <= r_flush_idx + 1'b1;
                    end
                end
                FWB0: if (w_done) r_state <= FWB1;
                FWB1: begin
                    if (w_done) begin
                        if (r_flush_idx == LAST_IDX) begin
                            r_state <= CNT;
                        end else begin
                            r_flush_idx <= r_flush_idx + 1'b1;
                            r_state     <= FLUSH;
                        end
                    end
                end
                CNT: if (w_done) r_state <= DONE;
                DONE: r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_dren     = 1'b0;
        w_dwen     = 1'b0;
        w_daddr    = '0;
        w_dstore   = '0;
        w_word_sel = 1'b0;
        case (r_state)
            WB0: begin
                w_dwen   = 1'b1;
                w_daddr  = victim_addr;
                w_dstore = victim_data;
            end
            WB1: begin
                w_dwen     = 1'b1;
                w_daddr    = victim_addr + 32'd4;
                w_dstore   = victim_data;
                w_word_sel = 1'b1;
            end
            FETCH0: begin
                w_dren  = 1'b1;
                w_daddr = block_word_addr(dmemaddr, 1'b0);
            end
            FETCH1: begin
                w_dren     = 1'b1;
                w_daddr    = block_word_addr(dmemaddr, 1'b1);
                w_word_sel = 1'b1;
            end
            FWB0: begin
                w_dwen   = 1'b1;
                w_daddr  = flush_addr;
                w_dstore = flush_data;
            end
            FWB1: begin
                w_dwen     = 1'b1;
                w_daddr    = flush_addr + 32'd4;
                w_dstore   = flush_data;
                w_word_sel = 1'b1;
            end
            CNT: begin
                w_dwen   = 1'b1;
                w_daddr  = HITCNT_ADDR;
                w_dstore = w_hit_count;
            end
            default: begin
            end
        endcase
    end

    hit_counter u_hit_counter (
        .CLK         (CLK),
        .RST         (RST),
        .i_hit_event (w_hit_event),
        .i_fill_done (fill_done),
        .o_count     (w_hit_count)
    );

    assign dREN      = w_dren;
    assign dWEN      = w_dwen;
    assign daddr     = w_daddr;
    assign dstore    = w_dstore;
    assign word_sel  = w_word_sel;
    assign fill_wen  = ((r_state == FETCH0) || (r_state == FETCH1)) && w_done;
    assign fill_done = (r_state == FETCH1) && w_done;
    assign clean     = ((r_state == WB1) || (r_state == FWB1)) && w_done;
    assign flush_idx = r_flush_idx;
    assign flushed   = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: the bench plays access logic and memory, and predicts the
// ordered list of memory operations, completion pulses and the stored hit count.
module tb_dcache_ctrl;
    import cpu_types_pkg::*;

    localparam int    NFRAMES = 16;
    localparam int    IDXW    = 4;
    localparam word_t HC_ADDR = 32'h0000_3100;
    localparam int    OPW     = 66;

    logic            CLK = 1'b0;
    logic            RST, dmemREN, dmemWEN, halt, hit, victim_dirty, dwait;
    word_t           victim_addr, victim_data, flush_addr, flush_data, dmemaddr;
    logic            flush_dirty, word_sel, fill_wen, fill_done, clean, dREN, dWEN, flushed;
    word_t           daddr, dstore, dload;
    logic [IDXW-1:0] flush_idx;
    dctrl_state_t    dbg_state;

    word_t vic_w0, vic_w1;
    logic  frame_dirty [NFRAMES];
    word_t frame_w0 [NFRAMES];
    word_t frame_w1 [NFRAMES];

    // Expected memory ops: {is_write, last_of_pair, addr, data}
    logic [OPW-1:0] exp_q[$];

    int    n_checks = 0;
    int    n_pass = 0;
    word_t hit_model;
    int    cyc_no = 0;
    int    flush_cycles, first_fill_cyc, first_flush_cyc, n_writes;
    int    wait_mode, wcnt, wtarget;
    logic  seen_fill;

    assign victim_data = word_sel ? vic_w1 : vic_w0;
    assign flush_dirty = frame_dirty[flush_idx];
    assign flush_addr  = 32'h0000_8000 + (32'(flush_idx) << 3);
    assign flush_data  = word_sel ? frame_w1[flush_idx] : frame_w0[flush_idx];
    assign dload       = daddr ^ 32'hA5A5_0000;

    dcache_ctrl #(.NFRAMES(NFRAMES), .HITCNT_ADDR(HC_ADDR)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt), .hit(hit),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .flush_dirty(flush_dirty), .flush_addr(flush_addr), .flush_data(flush_data),
        .dmemaddr(dmemaddr), .word_sel(word_sel), .fill_wen(fill_wen), .fill_done(fill_done),
        .clean(clean), .flush_idx(flush_idx), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload), .flushed(flushed), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void push_op(input logic we, input logic last, input word_t a, input word_t d);
        exp_q.push_back({we, last, a, d});
    endfunction

    function automatic word_t faddr(input int i);
        return 32'h0000_8000 + (32'(i) << 3);
    endfunction

    function automatic int new_target();
        return (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
    endfunction

    task automatic set_wait(input int mode);
        wait_mode = mode;
        wcnt      = 0;
        wtarget   = new_target();
    endtask

    task automatic monitor();
        logic [OPW-1:0] e;
        logic           done_now;
        cyc_no    = cyc_no + 1;
        seen_fill = fill_done;
        if (dbg_state == FLUSH) begin
            flush_cycles = flush_cycles + 1;
            if (first_flush_cyc < 0) first_flush_cyc = cyc_no;
        end
        if (fill_done && first_fill_cyc < 0) first_fill_cyc = cyc_no;
        chk("dren_dwen_exclusive", 32'(dREN & dWEN), 32'd0);
        done_now = (dREN | dWEN) & ~dwait;
        if (done_now) begin
            chk("op_expected", 32'(exp_q.size() != 0), 32'd1);
            if (dWEN) n_writes = n_writes + 1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("op_is_write", 32'(dWEN), 32'(e[65]));
                chk("op_addr", daddr, e[63:32]);
                if (e[65]) begin
                    chk("op_wdata", dstore, e[31:0]);
                    chk("clean_pulse", 32'(clean), 32'(e[64]));
                    chk("no_fill_on_write", 32'({fill_wen, fill_done}), 32'd0);
                end else begin
                    chk("fill_wen", 32'(fill_wen), 32'd1);
                    chk("fill_word_sel", 32'(word_sel), 32'(e[34]));
                    chk("fill_done_pulse", 32'(fill_done), 32'(e[64]));
                    chk("no_clean_on_read", 32'(clean), 32'd0);
                end
            end
        end else begin
            chk("no_pulse_without_completion", 32'({fill_wen, fill_done, clean}), 32'd0);
        end
    endtask

    // One clock cycle: memory decides dwait for the live request, outputs are checked
    // mid-cycle, then time advances to the next falling edge.
    task automatic step();
        #1;
        dwait = 1'b0;
        if (dREN || dWEN) begin
            if (wcnt < wtarget) begin
                dwait = 1'b1;
                wcnt  = wcnt + 1;
            end
        end
        #1;
        monitor();
        if ((dREN || dWEN) && !dwait) begin
            wcnt    = 0;
            wtarget = new_target();
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; hit = 1'b0;
        victim_dirty = 1'b0; dwait = 1'b0; dmemaddr = '0; victim_addr = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        hit_model = '0; flush_cycles = 0; first_fill_cyc = -1; first_flush_cyc = -1;
        n_writes = 0; wcnt = 0; wtarget = new_target();
    endtask

    task automatic chk_zero(input string p);
        #1;
        chk({p, "_state"}, 32'(dbg_state), 32'(IDLE));
        chk({p, "_mem_req"}, 32'({dREN, dWEN}), 32'd0);
        chk({p, "_daddr"}, daddr, 32'd0);
        chk({p, "_dstore"}, dstore, 32'd0);
        chk({p, "_pulses"}, 32'({fill_wen, fill_done, clean, word_sel}), 32'd0);
        chk({p, "_flush_idx"}, 32'(flush_idx), 32'd0);
        chk({p, "_flushed"}, 32'(flushed), 32'd0);
    endtask

    task automatic set_frames(input int mode);
        for (int i = 0; i < NFRAMES; i++) begin
            frame_w0[i]    = $urandom;
            frame_w1[i]    = $urandom;
            frame_dirty[i] = (mode == 1) ? 1'($urandom_range(0, 1)) :
                             (mode == 2) ? (i == 3 || i == 12) : 1'b0;
        end
    endtask

    task automatic do_hits(input int n);
        for (int i = 0; i < n; i++) begin
            dmemaddr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                dmemREN = 1'b1; dmemWEN = 1'b0;
            end else begin
                dmemREN = 1'b0; dmemWEN = 1'b1;
            end
            hit = 1'b1;
            step();
            hit_model = hit_model + 32'd1;
            if ($urandom_range(0, 2) == 0) begin
                dmemREN = 1'b0; dmemWEN = 1'b0; hit = 1'($urandom_range(0, 1));
                step();
            end
        end
        dmemREN = 1'b0; dmemWEN = 1'b0; hit = 1'b0;
    endtask

    task automatic do_miss(input word_t addr, input logic dirty, input word_t vaddr,
                           input logic wr, input logic hlt, output int cycles);
        int    steps;
        word_t fa;
        fa     = {addr[31:3], 3'b000};
        vic_w0 = $urandom;
        vic_w1 = $urandom;
        victim_addr  = vaddr;
        victim_dirty = dirty;
        if (dirty) begin
            push_op(1'b1, 1'b0, vaddr, vic_w0);
            push_op(1'b1, 1'b1, vaddr + 32'd4, vic_w1);
        end
        push_op(1'b0, 1'b0, fa, '0);
        push_op(1'b0, 1'b1, fa + 32'd4, '0);
        dmemaddr = addr; dmemREN = !wr; dmemWEN = wr; hit = 1'b0; halt = hlt;
        steps = 0; seen_fill = 1'b0;
        while (!seen_fill && steps < 200) begin
            step();
            steps = steps + 1;
        end
        chk("miss_completes", 32'(seen_fill), 32'd1);
        chk("miss_ops_drained", 32'(exp_q.size()), 32'd0);
        cycles = steps - 1;
        hit = 1'b1;
        step();
        dmemREN = 1'b0; dmemWEN = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
    endtask

    task automatic do_flush(input logic drop_halt);
        int steps;
        int nd;
        nd = 0;
        n_writes = 0;
        for (int i = 0; i < NFRAMES; i++) begin
            if (frame_dirty[i]) begin
                nd = nd + 1;
                push_op(1'b1, 1'b0, faddr(i), frame_w0[i]);
                push_op(1'b1, 1'b1, faddr(i) + 32'd4, frame_w1[i]);
            end
        end
        push_op(1'b1, 1'b0, HC_ADDR, hit_model);
        halt = 1'b1;
        steps = 0;
        while (!flushed && steps < 600) begin
            step();
            steps = steps + 1;
            if (drop_halt) halt = 1'b0;
        end
        chk("flushed_in_budget", 32'(flushed), 32'd1);
        chk("flush_ops_drained", 32'(exp_q.size()), 32'd0);
        chk("flush_visits", 32'(flush_cycles), 32'(NFRAMES));
        chk("flush_write_count", 32'(n_writes), 32'(2 * nd + 1));
        halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flushed_sticky", 32'(flushed), 32'd1);
            chk("done_no_mem", 32'({dREN, dWEN}), 32'd0);
        end
    endtask

    initial begin
        int    cyc;
        int    n;
        word_t ra, rv;
        int    kind;

        wait_mode = 0;
        set_frames(0);
        vic_w0 = '0; vic_w1 = '0;
        do_reset();
        chk_zero("reset");

        // Clean miss, two wait cycles per access: six cycles away from IDLE.
        set_wait(2);
        do_miss(32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0, cyc);
        chk("clean_miss_wait2_cycles", 32'(cyc), 32'd6);
        chk("idle_after_fill", 32'(dbg_state), 32'(IDLE));

        set_wait(0);
        ra = $urandom;
        do_miss(ra, 1'b0, 32'h0, 1'b1, 1'b0, cyc);
        chk("clean_miss_zero_wait_cycles", 32'(cyc), 32'd2);

        ra = $urandom;
        do_miss(ra, 1'b1, 32'h0000_0280, 1'b0, 1'b0, cyc);
        chk("dirty_miss_zero_wait_cycles", 32'(cyc), 32'd4);

        // Randomised mix of hits and misses under random memory latency.
        set_wait(-1);
        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rv = $urandom;
            rv[2:0] = 3'b000;
            kind = $urandom_range(0, 3);
            if (kind < 2) do_hits($urandom_range(1, 4));
            else do_miss(ra, kind == 3, rv, 1'($urandom_range(0, 1)), 1'b0, cyc);
        end
        set_frames(1);
        do_flush(1'b1);

        // 5 hits, one refilled miss, frames 3 and 12 dirty: count store of 5.
        do_reset();
        set_wait(-1);
        do_hits(5);
        do_miss(32'h0000_0540, 1'b0, 32'h0, 1'b0, 1'b0, cyc);
        set_frames(2);
        do_flush(1'b1);
        chk("hit_model_five", hit_model, 32'd5);

        // Reset during FETCH1 aborts, then a fully clean flush stores a zero count.
        do_reset();
        set_wait(2);
        do_hits(3);
        push_op(1'b0, 1'b0, 32'h0000_0700, '0);
        push_op(1'b0, 1'b1, 32'h0000_0704, '0);
        dmemaddr = 32'h0000_0700; dmemREN = 1'b1; hit = 1'b0; victim_dirty = 1'b0;
        n = 0;
        while (dbg_state != FETCH1 && n < 50) begin
            step();
            n = n + 1;
        end
        chk("reached_fetch1", 32'(dbg_state), 32'(FETCH1));
        RST = 1'b1; dwait = 1'b1;
        @(negedge CLK);
        chk_zero("rst_fetch1");
        RST = 1'b0; dmemREN = 1'b0; dwait = 1'b0;
        exp_q.delete();
        hit_model = '0; wcnt = 0; flush_cycles = 0;
        set_frames(0);
        do_flush(1'b0);

        // Miss raised together with halt: the fill finishes before flushing starts.
        do_reset();
        set_wait(-1);
        set_frames(1);
        frame_dirty[0] = 1'b1;
        do_miss(32'h0000_0A48, 1'b1, 32'h0000_0C00, 1'b0, 1'b1, cyc);
        do_flush(1'b0);
        chk("fill_seen", 32'(first_fill_cyc >= 0), 32'd1);
        chk("fill_before_flush", 32'(first_fill_cyc < first_flush_cyc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
